// File: rtl/vga_text_engine.sv
// Text-mode VGA engine: VGA timing, VRAM/font fetch and RGB render in a 3-tick pipeline.
// Optional blinking cursor is built only when VGA_TEXT_CURSOR_EN is defined.
module vga_text_engine #(
  parameter int H_VIS        = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_VIS        = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter bit SYNC_POL     = 1'b0,
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int CHAR_W       = 8,
  parameter int CHAR_H       = 16,
  parameter int ADDR_W       = 12,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                          clk_50mhz,
  input  logic                          rst,
  output logic [ADDR_W-1:0]             vram_addr,
  input  logic [15:0]                   vram_data,
  output logic [7+$clog2(CHAR_H):0]     font_addr,
  input  logic [7:0]                    font_data,
  input  logic [6:0]                    cursor_col,
  input  logic [4:0]                    cursor_row,
  input  logic                          cursor_en,
  output logic                          vga_hsync,
  output logic                          vga_vsync,
  output logic                          vga_red,
  output logic                          vga_green,
  output logic                          vga_blue,
  output logic                          frame_start
);
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int CW = $clog2(CHAR_W);
  localparam int RW = $clog2(CHAR_H);
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  // Per-pixel control that travels down the pipeline alongside the fetched data.
  typedef struct packed {
    logic          vis;
    logic          hs;
    logic          vs;
    logic          cur;
    logic [CW-1:0] px;
    logic [RW-1:0] gy;
  } ctl_t;

  logic          tick;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last, v_last;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;
  ctl_t          ctl_now, s0, s1;
  logic [2:0]    fg, bg;
  logic          blink_attr;
  logic [2:0]    bit_idx;
  logic          pix_on;
  logic [2:0]    rgb;
  logic          unused_ok;

  assign h_last = (h_cnt == HW'(H_TOTAL - 1));
  assign v_last = (v_cnt == VW'(V_TOTAL - 1));

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      tick        <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
    end else begin
      tick        <= ~tick;
      // Fires as the counters wrap back to (0,0), so it is high while they sit there.
      frame_start <= tick && h_last && v_last;
      if (tick) begin
        h_cnt <= h_last ? '0 : h_cnt + 1'b1;
        if (h_last) v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    ctl_now     = '0;
    ctl_now.vis = (h_cnt < HW'(H_VIS)) && (v_cnt < VW'(V_VIS));
    ctl_now.hs  = (h_cnt >= HW'(H_VIS + H_FP)) && (h_cnt < HW'(H_VIS + H_FP + H_SYNC));
    ctl_now.vs  = (v_cnt >= VW'(V_VIS + V_FP)) && (v_cnt < VW'(V_VIS + V_FP + V_SYNC));
    ctl_now.px  = h_cnt[CW-1:0];
    ctl_now.gy  = v_cnt[RW-1:0];
`ifdef VGA_TEXT_CURSOR_EN
    // Bottom two glyph rows of the cursor cell; out-of-range positions never match.
    ctl_now.cur = cursor_en && (int'(cursor_col) < COLS) && (int'(cursor_row) < ROWS)
                  && (int'(h_cnt >> CW) == int'(cursor_col))
                  && (int'(v_cnt >> RW) == int'(cursor_row))
                  && (int'(v_cnt[RW-1:0]) >= CHAR_H - 2);
`else
    ctl_now.cur = 1'b0;
`endif
  end

  always_comb begin
    bit_idx = 3'(CHAR_W - 1) - 3'(s1.px);
    pix_on  = font_data[bit_idx] && !(blink_attr && !blink_phase);
    rgb     = 3'b000;
    if (s1.vis) rgb = (pix_on || (s1.cur && blink_phase)) ? fg : bg;
  end

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      s0         <= '0;
      s1         <= '0;
      vram_addr  <= '0;
      font_addr  <= '0;
      fg         <= '0;
      bg         <= '0;
      blink_attr <= 1'b0;
      vga_hsync  <= ~SYNC_POL;
      vga_vsync  <= ~SYNC_POL;
      {vga_blue, vga_green, vga_red} <= 3'b000;
    end else if (tick) begin
      // S0: address the cell; hold the last address through blanking.
      s0 <= ctl_now;
      if (ctl_now.vis)
        vram_addr <= ADDR_W'((int'(v_cnt) >> RW) * COLS + (int'(h_cnt) >> CW));
      // S1: char/attr arrive; look up the glyph row.
      s1         <= s0;
      fg         <= vram_data[10:8];
      bg         <= vram_data[14:12];
      blink_attr <= vram_data[15];
      font_addr  <= {vram_data[7:0], s0.gy};
      // S2: glyph row arrives; syncs leave with the pixel they belong to.
      vga_hsync  <= s1.hs ? SYNC_POL : ~SYNC_POL;
      vga_vsync  <= s1.vs ? SYNC_POL : ~SYNC_POL;
      {vga_blue, vga_green, vga_red} <= rgb;
    end
  end

`ifdef VGA_TEXT_CURSOR_EN
  assign unused_ok = vram_data[11];
`else
  assign unused_ok = ^{vram_data[11], cursor_col, cursor_row, cursor_en};
`endif

endmodule

// File: tb/tb_vga_text_engine.sv
// Directed bench: full-size instance for pixel/sync/reset checks, shrunken instance for frame and blink.
module tb_vga_text_engine;
  logic clk = 1'b0, rst = 1'b1, s_rst = 1'b1;
  always #10 clk = ~clk;

  logic [11:0] vram_addr, font_addr, s_font_addr;
  logic [1:0]  s_vram_addr;
  logic [15:0] vram_data, s_vram_data;
  logic [7:0]  font_data, s_font_data;
  logic hs, vs, r, g, b, fs, s_hs, s_vs, s_r, s_g, s_b, s_fs;
  logic [15:0] vram [4096];
  logic [15:0] s_vram [4];
  logic [7:0]  font [4096];

  always @(posedge clk) begin
    vram_data   <= vram[vram_addr];
    font_data   <= font[font_addr];
    s_vram_data <= s_vram[s_vram_addr];
    s_font_data <= font[s_font_addr];
  end

  vga_text_engine u_dut (
    .clk_50mhz(clk), .rst(rst), .vram_addr(vram_addr), .vram_data(vram_data),
    .font_addr(font_addr), .font_data(font_data), .cursor_col(7'd80), .cursor_row(5'd0),
    .cursor_en(1'b1), .vga_hsync(hs), .vga_vsync(vs), .vga_red(r), .vga_green(g),
    .vga_blue(b), .frame_start(fs));

  vga_text_engine #(
    .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(2), .V_VIS(32), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .COLS(2), .ROWS(2), .ADDR_W(2), .BLINK_FRAMES(3)
  ) u_small (
    .clk_50mhz(clk), .rst(s_rst), .vram_addr(s_vram_addr), .vram_data(s_vram_data),
    .font_addr(s_font_addr), .font_data(s_font_data), .cursor_col(7'd1), .cursor_row(5'd1),
    .cursor_en(1'b1), .vga_hsync(s_hs), .vga_vsync(s_vs), .vga_red(s_r), .vga_green(s_g),
    .vga_blue(s_b), .frame_start(s_fs));

  // -1 in a field means "not checked at this sample"; rgb is {b,g,r}.
  typedef struct {
    int cyc; int rgb; int hs; int vs; int fs; int addr;
  } vec_t;
  vec_t tbl[$];
  int n_cmp = 0, n_fail = 0, cyc = 0;

`ifdef VGA_TEXT_CURSOR_EN
  localparam int CUR_RGB = 0;
`else
  localparam int CUR_RGB = 7;
`endif

  function automatic vec_t mk(int c, int rgb, int h, int v, int f, int a);
    vec_t e;
    e.cyc = c; e.rgb = rgb; e.hs = h; e.vs = v; e.fs = f; e.addr = a;
    return e;
  endfunction

  // Clock edge (after reset release) at which pixel (h,v) of frame f is on the outputs.
  function automatic int dp(int h, int v);
    return 2 * (v * 800 + h) + 6;
  endfunction
  function automatic int sp(int h, int v, int f);
    return 2 * (f * 912 + v * 24 + h) + 6;
  endfunction

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d expected %0d (t=%0t)", nm, idx, act, exp, $time);
    end
  endtask

  task automatic run_tbl(input bit sm);
    for (int i = 0; i < tbl.size(); i++) begin
      while (cyc < tbl[i].cyc) begin @(posedge clk); cyc++; end
      #1;
      if (tbl[i].rgb >= 0)  chk("rgb", i, sm ? int'({s_b, s_g, s_r}) : int'({b, g, r}), tbl[i].rgb);
      if (tbl[i].hs >= 0)   chk("hsync", i, sm ? int'(s_hs) : int'(hs), tbl[i].hs);
      if (tbl[i].vs >= 0)   chk("vsync", i, sm ? int'(s_vs) : int'(vs), tbl[i].vs);
      if (tbl[i].fs >= 0)   chk("frame_start", i, sm ? int'(s_fs) : int'(fs), tbl[i].fs);
      if (tbl[i].addr >= 0) chk("vram_addr", i, sm ? int'(s_vram_addr) : int'(vram_addr), tbl[i].addr);
    end
  endtask

  initial begin
    int k;
    for (int i = 0; i < 4096; i++) begin vram[i] = 16'h0; font[i] = 8'h0; end
    vram[0]   = 16'h0741;  // white on black 'A'
    vram[1]   = 16'h3242;  // green on yellow 'B'
    vram[79]  = 16'h7000;  // white background, last column
    vram[80]  = 16'h0141;  // red 'A', row 1
    vram[117] = 16'h7000;
    font[16'h41 * 16] = 8'h81;
    font[16'h42 * 16] = 8'hF0;
    s_vram[0] = 16'h8741;  // blinking white 'A'
    s_vram[1] = 16'h0741;
    s_vram[2] = 16'h0000;
    s_vram[3] = 16'h7000;  // cursor cell, white background, black fg

    repeat (3) @(posedge clk);
    #1;
    chk("rst_hsync", 0, hs, 1);
    chk("rst_vsync", 0, vs, 1);
    chk("rst_rgb", 0, {b, g, r}, 0);
    chk("rst_frame_start", 0, fs, 0);
    chk("rst_small_hsync", 0, s_hs, 1);

    tbl.push_back(mk(dp(0, 0),   7, 1, 1, -1, -1));
    tbl.push_back(mk(dp(1, 0),   0, -1, -1, -1, -1));
    tbl.push_back(mk(16,        -1, -1, -1, -1, 0));
    tbl.push_back(mk(dp(6, 0),   0, -1, -1, -1, -1));
    tbl.push_back(mk(18,        -1, -1, -1, -1, 1));
    tbl.push_back(mk(dp(7, 0),   7, -1, -1, -1, -1));
    tbl.push_back(mk(dp(8, 0),   2, -1, -1, -1, -1));
    tbl.push_back(mk(dp(11, 0),  2, -1, -1, -1, -1));
    tbl.push_back(mk(dp(12, 0),  3, -1, -1, -1, -1));
    tbl.push_back(mk(dp(15, 0),  3, -1, -1, -1, -1));
    tbl.push_back(mk(dp(16, 0),  0, -1, -1, -1, -1));
    tbl.push_back(mk(dp(632, 0), 7, -1, -1, -1, -1));
    tbl.push_back(mk(1282,      -1, -1, -1, -1, 79));
    tbl.push_back(mk(dp(639, 0), 7, -1, -1, -1, -1));
    tbl.push_back(mk(dp(640, 0), 0, 1, -1, -1, -1));
    tbl.push_back(mk(dp(655, 0), 0, 1, -1, -1, -1));
    tbl.push_back(mk(dp(656, 0), 0, 0, 1, -1, -1));
    tbl.push_back(mk(dp(751, 0), 0, 0, -1, -1, -1));
    tbl.push_back(mk(dp(752, 0), 0, 1, -1, -1, -1));
    tbl.push_back(mk(dp(799, 0), 0, 1, -1, 0, -1));
    tbl.push_back(mk(dp(0, 1),   0, 1, -1, -1, -1));
    tbl.push_back(mk(dp(8, 1),   3, -1, -1, -1, -1));
    tbl.push_back(mk(dp(655, 1), 0, 1, -1, -1, -1));
    tbl.push_back(mk(dp(656, 1), 0, 0, 1, -1, -1));
    tbl.push_back(mk(25602,     -1, -1, -1, -1, 80));
    tbl.push_back(mk(dp(0, 16),  1, -1, -1, -1, -1));
    tbl.push_back(mk(dp(1, 16),  0, -1, -1, -1, -1));
    tbl.push_back(mk(dp(7, 16),  1, -1, -1, -1, -1));

    @(negedge clk); rst = 1'b0; cyc = 0;
    run_tbl(1'b0);

    // Asynchronous reset mid-line: outputs must drop within the same clock.
    while (cyc < dp(297, 17)) begin @(posedge clk); cyc++; end
    #1;
    chk("pre_rst_rgb", 0, {b, g, r}, 7);
    chk("pre_rst_font_addr", 0, font_addr, 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_hsync", 0, hs, 1);
    chk("arst_vsync", 0, vs, 1);
    chk("arst_rgb", 0, {b, g, r}, 0);
    chk("arst_vram_addr", 0, vram_addr, 0);
    chk("arst_font_addr", 0, font_addr, 0);
    chk("arst_frame_start", 0, fs, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    k = 0;
    while (k < 4000) begin
      @(posedge clk); k++; #1;
      if (!hs) break;
    end
    chk("hsync_fall_clks", 0, k, 1318);

    tbl.delete();
    tbl.push_back(mk(1,             -1, -1, -1, 0, -1));
    tbl.push_back(mk(sp(0, 0, 0),    0, -1, 1, -1, -1));
    tbl.push_back(mk(sp(8, 0, 0),    7, -1, -1, -1, -1));
    tbl.push_back(mk(sp(17, 0, 0),  -1, 1, -1, -1, -1));
    tbl.push_back(mk(sp(18, 0, 0),  -1, 0, -1, -1, -1));
    tbl.push_back(mk(sp(8, 30, 0),   7, -1, -1, -1, -1));
    tbl.push_back(mk(sp(15, 31, 0),  7, -1, -1, -1, -1));
    tbl.push_back(mk(sp(0, 32, 0),   0, -1, -1, -1, -1));
    tbl.push_back(mk(sp(23, 33, 0), -1, -1, 1, -1, -1));
    tbl.push_back(mk(sp(0, 34, 0),  -1, -1, 0, -1, -1));
    tbl.push_back(mk(sp(23, 35, 0), -1, -1, 0, -1, -1));
    tbl.push_back(mk(sp(0, 36, 0),  -1, -1, 1, -1, -1));
    tbl.push_back(mk(1823,          -1, -1, -1, 0, -1));
    tbl.push_back(mk(1824,          -1, -1, -1, 1, -1));
    tbl.push_back(mk(1825,          -1, -1, -1, 0, -1));
    tbl.push_back(mk(sp(0, 0, 1),    0, -1, -1, -1, -1));
    tbl.push_back(mk(3648,          -1, -1, -1, 1, -1));
    tbl.push_back(mk(sp(0, 0, 2),    0, -1, -1, -1, -1));
    tbl.push_back(mk(sp(0, 0, 3),    7, -1, -1, -1, -1));
    tbl.push_back(mk(sp(8, 30, 3), CUR_RGB, -1, -1, -1, -1));
    tbl.push_back(mk(sp(0, 0, 4),    7, -1, -1, -1, -1));
    tbl.push_back(mk(sp(0, 0, 5),    7, -1, -1, -1, -1));
    tbl.push_back(mk(sp(0, 0, 6),    0, -1, -1, -1, -1));
    tbl.push_back(mk(sp(0, 0, 7),    0, -1, -1, -1, -1));

    @(negedge clk); s_rst = 1'b0; cyc = 0;
    run_tbl(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_text_engine.md
Name: vga_text_engine

Overview:
- Parametrised text-mode VGA display engine, the successor to the fixed 640x480 single-colour character display.
- Generates VGA timing from clk_50mhz using a 25 MHz pixel enable.
- Fetches character/attribute words from an external video RAM and glyph rows from an external font ROM.
- Renders per-character foreground/background colour, attribute blink and an optional blinking cursor, with sync outputs pipeline-aligned to pixel data.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of hsync/vsync
- COLS, 80, text columns (H_VIS/CHAR_W)
- ROWS, 30, text rows (V_VIS/CHAR_H)
- CHAR_W, 8, glyph width; power of two, max 8
- CHAR_H, 16, glyph height; power of two
- ADDR_W, 12, vram address width; 2^ADDR_W >= COLS*ROWS
- BLINK_FRAMES, 30, frames per blink half-period

Ports:
- clk_50mhz  in  1  system clock, 50 MHz
- rst  in  1  reset, asynchronous, active-high
- vram_addr  out  ADDR_W  character cell address = row*COLS+col
- vram_data  in  16  [7:0] char code; [10:8] fg {b,g,r}; [14:12] bg {b,g,r}; [15] blink; others ignored; valid 1 clk after vram_addr
- font_addr  out  8+log2(CHAR_H)  {char code, glyph row}
- font_data  in  8  glyph row, MSB = leftmost pixel; valid 1 clk after font_addr
- cursor_col  in  7  cursor column
- cursor_row  in  5  cursor row
- cursor_en  in  1  cursor enable
- vga_hsync  out  1  horizontal sync
- vga_vsync  out  1  vertical sync
- vga_red, vga_green, vga_blue  out  1 each  pixel colour
- frame_start  out  1  one-clk pulse at tick where h=0,v=0

Behaviour:
- Reset (async, immediate): tick=0, h_cnt=0, v_cnt=0, all pipeline registers cleared; vga_hsync=vga_vsync=~SYNC_POL; RGB=0; vram_addr=0; font_addr=0; frame_start=0; frame counter=0; blink_phase=0.
- Pixel tick: toggles every clk_50mhz; all counters and pipeline stages advance only when tick=1.
- h_cnt counts 0..H_TOTAL-1 (H_TOTAL=H_VIS+H_FP+H_SYNC+H_BP=800), then wraps to 0. v_cnt increments at each h wrap and counts 0..V_TOTAL-1 (525), then wraps.
- Sync: raw hsync active for h_cnt in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC); raw vsync likewise on v_cnt.
- Pipeline, 3 ticks deep:
  - S0: drive vram_addr from h_cnt/CHAR_W and v_cnt/CHAR_H.
  - S1: capture vram_data; drive font_addr = {char, v_cnt%CHAR_H}; delay attributes.
  - S2: capture font_data; select bit (CHAR_W-1 - h%CHAR_W); register RGB and syncs.
- Outputs for counter position (h,v) appear exactly 3 ticks (6 clks) after the counters reach (h,v). Syncs are delayed identically, so there is no skew.
- Blanking: outside visible area (delayed), RGB=000 regardless of data.
- Colour: pixel on -> fg, pixel off -> bg, mapped to {vga_blue, vga_green, vga_red}.
- Blink: frame counter increments at each frame_start. On reaching BLINK_FRAMES-1 it wraps to 0 and toggles blink_phase. While blink_phase=0, cells with attr[15]=1 render bg only.
- frame_start: one clk_50mhz-cycle pulse, not delayed by the pipeline.
- Off-screen addresses are never issued: vram_addr holds its last value while h or v is non-visible.
- Out-of-range cursor position (col>=COLS or row>=ROWS): cursor is never drawn.

Optional Feature:
VGA_TEXT_CURSOR_EN
- Defined: when cursor_en=1 and blink_phase=1, glyph rows CHAR_H-2 and CHAR_H-1 of cell (cursor_col, cursor_row) are forced to fg. This is an XOR-free overwrite.
- Undefined: cursor logic is not built; cursor ports are ignored and outputs are identical to a design with cursor_en=0.

Test Plan:
- Release rst, font/vram zero -> hsync low for 192 clks per line, line period 1600 clks, vsync low 2 lines, frame_start period 840000 clks.
- vram[0]=0x0741, font row0 of 0x41=0x81 -> line 0: pixel 0=white(111), pixels 1-6=000, pixel 7=111, first pixel 6 clks after h=0; vram_addr=1 issued at h=8.
- Font all 0xFF, attr fg=010 -> visible pixels green; h_cnt 640..799 and v_cnt 480..524 give RGB=000.
- vram[5]=0x8741 -> glyph visible in frames 30-59, shown bg-only in frames 0-29 and 60-89; blink_phase toggles every 30 frame_start pulses.
- VGA_TEXT_CURSOR_EN, cursor (1,0), en=1, blank char attr 0x0700 -> pixels x=8..15, y=14..15 white only while blink_phase=1; with cursor_col=80 nothing is drawn.
- Assert rst at h=300 v=100 -> all outputs at reset values within the same clk; after release, first hsync falling edge occurs 659 ticks later.
